// File: rtl/game_pkg.sv
// Shared motion states and screen geometry for the sprite pipeline.
package game_pkg;

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2
   } motion_state_t;

   localparam int HOR_PIXELS  = 800;
   localparam int VER_PIXELS  = 600;
   localparam int SPRITE_SIZE = 64;

endpackage

// File: rtl/player_motion.sv
// Held direction/jump keys to sprite top-left coordinates, stepped once per frame_tick.
// Registered outputs change one clk after a tick and hold otherwise; no backpressure.
module player_motion
   import game_pkg::*;
#(
   parameter int CW        = 12,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = HOR_PIXELS - SPRITE_SIZE,
   parameter int X_INIT    = (HOR_PIXELS - SPRITE_SIZE) / 2,
   parameter int Y_FLOOR   = VER_PIXELS - SPRITE_SIZE,
   parameter int WALK_STEP = 2,
   parameter int JUMP_V0   = 12,
   parameter int GRAVITY   = 1,
   parameter int V_MAX     = 12
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_tick,
   input  logic          key_left,
   input  logic          key_right,
   input  logic          key_jump,
   output logic [CW-1:0] xpos,
   output logic [CW-1:0] ypos,
   output logic          facing_left,
   output logic          in_air,
   output logic [1:0]    state
);

   localparam int VW = $clog2(((JUMP_V0 > V_MAX) ? JUMP_V0 : V_MAX) + 1) + 1;

   localparam logic signed [CW:0] WALK_S  = (CW+1)'(WALK_STEP);
   localparam logic signed [CW:0] XMIN_S  = (CW+1)'(X_MIN);
   localparam logic signed [CW:0] XMAX_S  = (CW+1)'(X_MAX);
   localparam logic signed [CW:0] FLOOR_S = (CW+1)'(Y_FLOOR);
   localparam logic signed [CW:0] GRAV_S  = (CW+1)'(GRAVITY);
   localparam logic signed [CW:0] VMAX_S  = (CW+1)'(V_MAX);
   localparam logic [CW-1:0]      XMIN_C  = CW'(X_MIN);
   localparam logic [CW-1:0]      XMAX_C  = CW'(X_MAX);
   localparam logic [CW-1:0]      XINIT_C = CW'(X_INIT);
   localparam logic [CW-1:0]      FLOOR_C = CW'(Y_FLOOR);
   localparam logic [VW-1:0]      V0_C    = VW'(JUMP_V0);

   motion_state_t  state_q;
   logic [CW-1:0]  xpos_q, ypos_q;
   logic [VW-1:0]  vy_q;
   logic           facing_q, in_air_q;
   logic           key_jump_q, jump_req, jump_edge;

   // All candidate sums carry an extra sign bit so saturation never sees a wrapped value.
   logic signed [CW:0] x_s, x_left, x_right;
   logic signed [CW:0] y_s, vy_s, rise_y, rise_vy, fall_vy_raw, fall_vy, fall_y;

   assign x_s         = $signed({1'b0, xpos_q});
   assign x_left      = x_s - WALK_S;
   assign x_right     = x_s + WALK_S;
   assign y_s         = $signed({1'b0, ypos_q});
   assign vy_s        = $signed({{(CW+1-VW){1'b0}}, vy_q});
   assign rise_y      = y_s - vy_s;
   assign rise_vy     = vy_s - GRAV_S;
   assign fall_vy_raw = vy_s + GRAV_S;
   assign fall_vy     = (fall_vy_raw > VMAX_S) ? VMAX_S : fall_vy_raw;
   assign fall_y      = y_s + fall_vy;

   assign jump_edge   = key_jump & ~key_jump_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_GROUND;
         xpos_q     <= XINIT_C;
         ypos_q     <= FLOOR_C;
         vy_q       <= '0;
         facing_q   <= 1'b0;
         in_air_q   <= 1'b0;
         key_jump_q <= 1'b0;
         jump_req   <= 1'b0;
      end else begin
         key_jump_q <= key_jump;
         if (frame_tick)
            jump_req <= 1'b0;
         else if (jump_edge)
            jump_req <= 1'b1;

         if (frame_tick) begin
            if (key_left && !key_right) begin
               xpos_q   <= (x_left < XMIN_S) ? XMIN_C : x_left[CW-1:0];
               facing_q <= 1'b1;
            end else if (key_right && !key_left) begin
               xpos_q   <= (x_right > XMAX_S) ? XMAX_C : x_right[CW-1:0];
               facing_q <= 1'b0;
            end

            case (state_q)
               ST_GROUND: begin
                  // An edge arriving with the tick itself is taken here, not lost.
                  if (jump_req || jump_edge) begin
                     state_q  <= ST_RISE;
                     vy_q     <= V0_C;
                     in_air_q <= 1'b1;
                  end else begin
                     ypos_q <= FLOOR_C;
                  end
               end
               ST_RISE: begin
                  ypos_q <= rise_y[CW] ? '0 : rise_y[CW-1:0];
                  if (rise_vy[CW] || (rise_vy == '0)) begin
                     state_q <= ST_FALL;
                     vy_q    <= '0;
                  end else begin
                     vy_q <= rise_vy[VW-1:0];
                  end
               end
               ST_FALL: begin
                  if (fall_y >= FLOOR_S) begin
                     state_q  <= ST_GROUND;
                     ypos_q   <= FLOOR_C;
                     vy_q     <= '0;
                     in_air_q <= 1'b0;
                  end else begin
                     ypos_q <= fall_y[CW-1:0];
                     vy_q   <= fall_vy[VW-1:0];
                  end
               end
               default: begin
                  state_q  <= ST_GROUND;
                  ypos_q   <= FLOOR_C;
                  vy_q     <= '0;
                  in_air_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign xpos        = xpos_q;
   assign ypos        = ypos_q;
   assign facing_left = facing_q;
   assign in_air      = in_air_q;
   assign state       = state_q;

endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Parametrised successor to the keyboard-driven sprite movement block: converts held direction/jump keys into sprite top-left coordinates for the sprite drawer.
- Adds per-frame stepping, screen-edge saturation, a jump/gravity state machine and facing direction.
- Sits between the keyboard decode path and the sprite draw stage, clocked on the 40 MHz pixel clock.

Parameters:
- CW, 12, coordinate width in bits for xpos/ypos.
- X_MIN, 0, leftmost allowed xpos.
- X_MAX, 736, rightmost allowed xpos (800 − 64-pixel sprite).
- X_INIT, 368, xpos after reset.
- Y_FLOOR, 536, ypos when standing (600 − 64).
- WALK_STEP, 2, horizontal pixels per frame.
- JUMP_V0, 12, initial upward velocity (pixels/frame).
- GRAVITY, 1, velocity change per frame.
- V_MAX, 12, terminal falling velocity.

Ports:
- clk, in, 1: 40 MHz clock.
- rst, in, 1: reset. Synchronous, active-high.
- frame_tick, in, 1: one-cycle pulse per frame, produced upstream from vsync.
- key_left, in, 1: left key held (level).
- key_right, in, 1: right key held (level).
- key_jump, in, 1: jump key held (level).
- xpos, out, CW: sprite x.
- ypos, out, CW: sprite y.
- facing_left, out, 1: 1 means the sprite is mirrored.
- in_air, out, 1: high in RISE/FALL.
- state, out, 2: current motion_state_t.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset rst is synchronous, active-high.
  - All key inputs are already synchronous to clk; the crossing from the keyboard clock domain is done upstream.
  - Reset values: xpos=X_INIT, ypos=Y_FLOOR, vy=0, state=ST_GROUND, facing_left=0, in_air=0, jump_req=0.
  - rst asserted mid-jump returns to these values on the next edge, with no residual velocity.
- Jump request:
  - key_jump is registered every clk; a 0→1 edge sets jump_req.
  - A held key does not re-trigger a jump.
  - jump_req clears on every frame_tick, whether or not it was consumed.
  - An edge coinciding with frame_tick is not lost: it is consumed by that tick.
- Timing:
  - Position, velocity and state update only in cycles where frame_tick=1.
  - Outputs are registered and valid one clk after the tick.
  - Without a tick, outputs hold.
- Horizontal motion (every tick, all states):
  - left only: xpos=max(X_MIN, xpos−WALK_STEP), facing_left=1.
  - right only: xpos=min(X_MAX, xpos+WALK_STEP), facing_left=0.
  - both or neither: xpos and facing_left unchanged.
  - Saturation is computed in CW+1 bits signed, so there is no wrap below 0 or above X_MAX.
- Vertical state machine (motion_state_t):
  - ST_GROUND:
    - On tick with jump_req: go to ST_RISE, vy=JUMP_V0, ypos unchanged this tick.
    - Otherwise ypos stays at Y_FLOOR.
  - ST_RISE, on tick:
    - ypos=max(0, ypos−vy); vy=vy−GRAVITY.
    - If the new vy ≤ 0: go to ST_FALL with vy=0.
  - ST_FALL, on tick:
    - vy_n=min(vy+GRAVITY, V_MAX).
    - If ypos+vy_n ≥ Y_FLOOR: ypos=Y_FLOOR, vy=0, go to ST_GROUND.
    - Otherwise ypos+=vy_n.
  - In ST_RISE/ST_FALL, jump_req is ignored (cleared on tick); there is no double jump.
  - Encoding value 3 is illegal and recovers to ST_GROUND with ypos=Y_FLOOR.
- Status outputs: in_air = (state != ST_GROUND).
- Arithmetic:
  - vy is unsigned, width $clog2(max(JUMP_V0,V_MAX)+1)+1.
  - Intermediate ypos sums are computed at CW+1 bits.

Decomposition:
- game_pkg holds:
  - typedef enum logic [1:0] motion_state_t {ST_GROUND, ST_RISE, ST_FALL}.
  - Shared screen constants HOR_PIXELS=800, VER_PIXELS=600, SPRITE_SIZE=64.
- Parameter defaults derive from these constants.
- No sub-module is needed; the jump edge detector is a few inline flops.

Test Plan:
- Reset, then 10 ticks with no keys → xpos=368, ypos=536, state=ST_GROUND, in_air=0.
- key_right held for 200 ticks → xpos saturates at 736 after 184 ticks and stays there, facing_left=0. Then key_left for 1 tick → xpos=734, facing_left=1.
- key_jump pulsed once:
  - After tick 1 → state=ST_RISE, ypos=536.
  - After 12 more ticks → ypos=458 (536−78), state=ST_FALL.
  - Then FALL ticks add 1, 2, … until ypos=536 and state=ST_GROUND; total airtime is 25 ticks.
- key_jump held continuously across the landing → no second jump. Release, then press again → new jump starts on the next tick.
- Both key_left and key_right held for 20 ticks → xpos and facing_left unchanged. Jump edge in the same cycle as frame_tick → jump starts on that tick.
- Assert rst for one cycle at the jump apex (ypos=458) → next cycle ypos=536, vy=0, ST_GROUND. The following tick without keys leaves ypos=536.
